ofs_fim_axis_elastic_pipeline: RTL and testbench
================================================

// Module: ofs_fim_axis_elastic_pipeline
// PURPOSE
//  Parametrised AXIS register chain: PL_DEPTH full-throughput skid-buffer stages between a sink and a source port.
//  Adds a live beat-occupancy count and a packet-boundary pause gate (stalls egress only between packets).
//  Used on PCIe SS TX/RX paths for timing closure, and for clean traffic quiescing ahead of FLR/port reset.
// PARAMETERS
//  TDATA_WIDTH     512  tdata width (bits); TKEEP width is TDATA_WIDTH/8
//  TUSER_WIDTH     10   tuser (tuser_vendor) width
//  PL_DEPTH        2    number of skid stages; 0 = combinational pass-through (pause gate still registered)
//  TREADY_RST_VAL  0    s_tready value while rst_n=0 (1 = accept-and-drop during reset)
//  ENABLE_TKEEP    1    0: m_tkeep tied all-ones, s_tkeep ignored
//  OCC_W           $clog2(2*PL_DEPTH+1) (derived localparam, min 1) occupancy width
// PORTS
//  clk        in   1              clock
//  rst_n      in   1              synchronous active-low reset
//  s_tvalid   in   1              ingress valid
//  s_tready   out  1              ingress ready
//  s_tdata    in   TDATA_WIDTH    ingress data
//  s_tkeep    in   TDATA_WIDTH/8  ingress byte enables
//  s_tlast    in   1              ingress end of packet
//  s_tuser    in   TUSER_WIDTH    ingress user sideband
//  m_tvalid   out  1              egress valid
//  m_tready   in   1              egress ready
//  m_tdata    out  TDATA_WIDTH    egress data
//  m_tkeep    out  TDATA_WIDTH/8  egress byte enables
//  m_tlast    out  1              egress end of packet
//  m_tuser    out  TUSER_WIDTH    egress user sideband
//  pause      in   1              request: stop egress at the next packet boundary
//  paused     out  1              gate engaged; no egress beat presented
//  occupancy  out  OCC_W          beats currently held in all stages (0..2*PL_DEPTH)
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): all stage main/skid valids=0, out_in_pkt=0, gate_r=0, occupancy=0.
//   Outputs during reset: m_tvalid=0, paused=0, s_tready=TREADY_RST_VAL; beats offered during reset are dropped.
//   Reset mid-packet discards every held beat; no partial packet is emitted after reset.
//  Stage n: main reg + skid reg. s_tready(n) = ~skid_valid(n) (registered); accept when valid&ready.
//   If main empty or downstream takes main this cycle, incoming beat -> main; else -> skid.
//   On downstream take with skid full: skid -> main, skid emptied. Data regs need no reset.
//  Latency: 1 cycle per stage (PL_DEPTH cycles s->m when unstalled); throughput 1 beat/clk sustained.
//  Full: skid full -> s_tready(n)=0 next cycle; no beat is ever dropped or duplicated; order preserved.
//  Occupancy: sum of all main+skid valids, registered, updated every clk; simultaneous in+out leaves it unchanged.
//  Pause gate (at egress of last stage):
//   out_in_pkt: set on accepted beat with tlast=0, cleared on accepted beat with tlast=1; in_pkt_next = its next value.
//   gate_r <= pause when !(m_tvalid && !m_tready) && !in_pkt_next; else gate_r holds.
//   m_tvalid = last_valid & ~gate_r; last-stage downstream ready = m_tready & ~gate_r; paused = gate_r.
//   Never drops m_tvalid for a beat that is already presented (AXIS-compliant); never splits a packet.
//   pause asserted mid-packet: gate engages the cycle after the tlast beat is accepted.
//   pause deasserted: gate releases next clk; held beat is re-presented with unchanged data.
//   Single-beat packet accepted in the same cycle pause rises: gate engages next clk.
//  PL_DEPTH=0: m_* = s_* gated by gate_r; s_tready = m_tready & ~gate_r; occupancy=0.
// TESTING
//  1 Stream 64 beats, m_tready=1, PL_DEPTH=2 -> first beat at m after 2 clks, 1 beat/clk, data/order exact.
//  2 m_tready=0 for 10 clks under full ingress -> occupancy ramps to 4, s_tready=0; release -> all 4 drained in order.
//  3 Random s_tvalid/m_tready (50%) over 10k beats -> scoreboard match, occupancy == model each clk.
//  4 pause=1 at beat 2 of 5-beat pkt -> beats 3-5 delivered, then m_tvalid=0, paused=1; pause=0 -> pkt 2 resumes.
//  5 pause=1 while m_tvalid=1, m_tready=0, no pkt open -> m_tvalid stays 1 until accepted, then gate engages.
//  6 rst_n=0 mid-packet with occupancy=3 -> next clk m_tvalid=0, occupancy=0, s_tready=TREADY_RST_VAL.

Source files
------------

// File: rtl/ofs_fim_axis_elastic_pipeline.sv
// ofs_fim_axis_elastic_pipeline
//   AXI-Stream register chain of PL_DEPTH full-throughput skid-buffer stages,
//   with a live beat-occupancy count and a packet-boundary pause gate on egress.
//   Used on PCIe SS TX/RX paths for timing closure and for quiescing traffic
//   cleanly ahead of FLR / port reset.
//
// Ports
//   clk, rst_n                    clock, synchronous active-low reset
//   s_tvalid/s_tready/s_t*        ingress AXIS (tdata, tkeep, tlast, tuser)
//   m_tvalid/m_tready/m_t*        egress AXIS
//   pause                         request: stop egress at the next packet boundary
//   paused                        gate engaged; no egress beat is presented
//   occupancy                     beats held across all stages (0..2*PL_DEPTH)
//
// PL_DEPTH=0 gives a combinational pass-through; the pause gate stays registered.

module ofs_fim_axis_elastic_pipeline #(
  parameter int unsigned TDATA_WIDTH    = 512,
  parameter int unsigned TUSER_WIDTH    = 10,
  parameter int unsigned PL_DEPTH       = 2,
  parameter bit          TREADY_RST_VAL = 1'b0,
  parameter bit          ENABLE_TKEEP   = 1'b1,
  localparam int unsigned KW            = TDATA_WIDTH / 8,
  localparam int unsigned OCC_W         = (PL_DEPTH == 0) ? 1 : $clog2(2 * PL_DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,

  input  logic                   s_tvalid,
  output logic                   s_tready,
  input  logic [TDATA_WIDTH-1:0] s_tdata,
  input  logic [KW-1:0]          s_tkeep,
  input  logic                   s_tlast,
  input  logic [TUSER_WIDTH-1:0] s_tuser,

  output logic                   m_tvalid,
  input  logic                   m_tready,
  output logic [TDATA_WIDTH-1:0] m_tdata,
  output logic [KW-1:0]          m_tkeep,
  output logic                   m_tlast,
  output logic [TUSER_WIDTH-1:0] m_tuser,

  input  logic                   pause,
  output logic                   paused,
  output logic [OCC_W-1:0]       occupancy
);

  localparam int unsigned PW = TDATA_WIDTH + KW + 1 + TUSER_WIDTH;

  // link n is the input of stage n; link PL_DEPTH is the egress of the chain
  logic [PL_DEPTH:0]         link_valid;
  logic [PL_DEPTH:0]         link_ready;
  logic [PL_DEPTH:0][PW-1:0] link_data;

  logic          gate_r;
  logic          out_in_pkt;
  logic          in_pkt_next;
  logic          m_fire;
  logic [KW-1:0] keep_in;

  assign keep_in       = ENABLE_TKEEP ? s_tkeep : '1;
  assign link_valid[0] = s_tvalid;
  assign link_data[0]  = {s_tdata, keep_in, s_tlast, s_tuser};

  // The gate also blocks the last stage from handing off, so a gated beat
  // stays parked in the chain and is re-presented unchanged on release.
  assign link_ready[PL_DEPTH] = m_tready & ~gate_r;

  for (genvar n = 0; n < PL_DEPTH; n++) begin : g_stage
    logic          main_valid;
    logic          skid_valid;
    logic [PW-1:0] main_data;
    logic [PW-1:0] skid_data;
    logic          in_fire;
    logic          out_fire;

    // Ready depends only on the registered skid flag, which breaks the
    // combinational ready path between stages.
    assign link_ready[n] = ~skid_valid;
    assign in_fire       = link_valid[n] & ~skid_valid;
    assign out_fire      = main_valid & link_ready[n+1];

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        main_valid <= 1'b0;
        skid_valid <= 1'b0;
      end else if (out_fire) begin
        // skid full implies in_fire=0, so at most one source refills main
        main_valid <= skid_valid | in_fire;
        skid_valid <= 1'b0;
      end else if (!main_valid) begin
        main_valid <= in_fire;
      end else if (in_fire) begin
        skid_valid <= 1'b1;
      end
    end

    always_ff @(posedge clk) begin
      if (out_fire) begin
        main_data <= skid_valid ? skid_data : link_data[n];
      end else if (!main_valid) begin
        main_data <= link_data[n];
      end
      if (in_fire && main_valid && !out_fire) begin
        skid_data <= link_data[n];
      end
    end

    assign link_valid[n+1] = main_valid;
    assign link_data[n+1]  = main_data;
  end

  if (PL_DEPTH > 0) begin : g_occ
    logic [OCC_W-1:0] occ_r;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        occ_r <= '0;
      end else begin
        occ_r <= occ_r + OCC_W'(link_valid[0] & link_ready[0])
                       - OCC_W'(link_valid[PL_DEPTH] & link_ready[PL_DEPTH]);
      end
    end

    assign occupancy = occ_r;
  end else begin : g_no_occ
    assign occupancy = '0;
  end

  assign s_tready = rst_n ? link_ready[0] : TREADY_RST_VAL;
  assign m_tvalid = link_valid[PL_DEPTH] & ~gate_r & rst_n;
  assign {m_tdata, m_tkeep, m_tlast, m_tuser} = link_data[PL_DEPTH];
  assign paused   = gate_r & rst_n;

  assign m_fire      = m_tvalid & m_tready;
  assign in_pkt_next = m_fire ? ~m_tlast : out_in_pkt;

  // The gate may only change while no beat is stalled on the egress and no
  // packet is open, so a presented beat is never withdrawn and a packet is
  // never split.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_in_pkt <= 1'b0;
      gate_r     <= 1'b0;
    end else begin
      out_in_pkt <= in_pkt_next;
      if (!(m_tvalid && !m_tready) && !in_pkt_next) begin
        gate_r <= pause;
      end
    end
  end

endmodule

// File: tb/tb_ofs_fim_axis_elastic_pipeline.sv
`timescale 1ns/1ps

module tb_ofs_fim_axis_elastic_pipeline;

  localparam int DW = 32;
  localparam int UW = 10;
  localparam int KW = DW / 8;
  localparam int D  = 2;
  localparam int OW = 3;
  localparam int PW = DW + KW + 1 + UW;

  logic          clk;
  logic          rst_n;
  logic          s_tvalid;
  logic          s_tready;
  logic [DW-1:0] s_tdata;
  logic [KW-1:0] s_tkeep;
  logic          s_tlast;
  logic [UW-1:0] s_tuser;
  logic          m_tvalid;
  logic          m_tready;
  logic [DW-1:0] m_tdata;
  logic [KW-1:0] m_tkeep;
  logic          m_tlast;
  logic [UW-1:0] m_tuser;
  logic          pause;
  logic          paused;
  logic [OW-1:0] occupancy;

  ofs_fim_axis_elastic_pipeline #(
    .TDATA_WIDTH    (DW),
    .TUSER_WIDTH    (UW),
    .PL_DEPTH       (D),
    .TREADY_RST_VAL (1'b0),
    .ENABLE_TKEEP   (1'b1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_tvalid  (s_tvalid),
    .s_tready  (s_tready),
    .s_tdata   (s_tdata),
    .s_tkeep   (s_tkeep),
    .s_tlast   (s_tlast),
    .s_tuser   (s_tuser),
    .m_tvalid  (m_tvalid),
    .m_tready  (m_tready),
    .m_tdata   (m_tdata),
    .m_tkeep   (m_tkeep),
    .m_tlast   (m_tlast),
    .m_tuser   (m_tuser),
    .pause     (pause),
    .paused    (paused),
    .occupancy (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [PW-1:0] sb_q[$];
  int unsigned   seq = 0;
  int            occ_model = 0;
  int unsigned   n_in = 0;
  int unsigned   n_out = 0;
  logic          sf;
  logic          mf;
  logic          last_in_tlast = 1'b1;

  typedef struct {
    bit sv;
    bit mr;
    bit e_str;
    bit e_mv;
    int e_occ;
  } vec_t;

  vec_t tbl[15];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive payload for the next beat, then sample at the falling edge.
  task automatic sample();
    logic [PW-1:0] exp_b;
    s_tdata = 32'hC0DE0000 ^ (seq * 32'h00010003);
    s_tkeep = seq[3:0];
    s_tuser = seq[9:0] ^ 10'h2A5;
    @(negedge clk);
    sf = rst_n & s_tvalid & s_tready;
    mf = rst_n & m_tvalid & m_tready;
    if (rst_n) begin
      chk("occupancy", 64'(occupancy), 64'(occ_model));
      if (mf) begin
        chk("sb_nonempty", 64'(sb_q.size() > 0), 64'd1);
        if (sb_q.size() > 0) begin
          exp_b = sb_q.pop_front();
          chk("egress_beat", 64'({m_tdata, m_tkeep, m_tlast, m_tuser}), 64'(exp_b));
        end
      end
    end
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
    if (!rst_n) begin
      sb_q.delete();
      occ_model = 0;
    end else begin
      if (sf) begin
        sb_q.push_back({s_tdata, s_tkeep, s_tlast, s_tuser});
        seq++;
        n_in++;
        occ_model++;
        last_in_tlast = s_tlast;
      end
      if (mf) begin
        n_out++;
        occ_model--;
      end
    end
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned base;
    int unsigned cyc;
    int unsigned acc0;

    // cycle-by-cycle stall/drain table starting from an empty pipe
    tbl[0]  = '{1, 0, 1, 0, 0};
    tbl[1]  = '{1, 0, 1, 0, 1};
    tbl[2]  = '{1, 0, 1, 1, 2};
    tbl[3]  = '{1, 0, 1, 1, 3};
    for (int i = 4; i < 10; i++) tbl[i] = '{1, 0, 0, 1, 4};
    tbl[10] = '{0, 1, 0, 1, 4};
    tbl[11] = '{0, 1, 0, 1, 3};
    tbl[12] = '{0, 1, 1, 1, 2};
    tbl[13] = '{0, 1, 1, 1, 1};
    tbl[14] = '{0, 1, 1, 0, 0};

    rst_n = 1'b0; s_tvalid = 1'b0; s_tlast = 1'b1; m_tready = 1'b0; pause = 1'b0;

    // reset
    for (int c = 0; c < 3; c++) begin
      s_tvalid = 1'b1;
      sample();
      chk("rst_s_tready", 64'(s_tready), 64'd0);
      chk("rst_m_tvalid", 64'(m_tvalid), 64'd0);
      chk("rst_paused", 64'(paused), 64'd0);
      advance();
    end
    rst_n = 1'b1; s_tvalid = 1'b0;
    sample();
    chk("post_rst_occ", 64'(occupancy), 64'd0);
    chk("post_rst_s_tready", 64'(s_tready), 64'd1);
    chk("post_rst_m_tvalid", 64'(m_tvalid), 64'd0);
    chk("post_rst_paused", 64'(paused), 64'd0);
    advance();

    // 1: 64-beat stream, 2-cycle latency, 1 beat/clk
    base = n_out;
    m_tready = 1'b1;
    for (int k = 0; k < 66; k++) begin
      s_tvalid = (k < 64);
      s_tlast  = 1'b1;
      sample();
      chk("t1_m_tvalid", 64'(m_tvalid), 64'(k >= 2 && k <= 65));
      chk("t1_s_tready", 64'(s_tready), 64'd1);
      advance();
    end
    chk("t1_count", 64'(n_out - base), 64'd64);

    // 2: full ingress against a stalled egress, then drain
    base = n_out;
    for (int i = 0; i < 15; i++) begin
      s_tvalid = tbl[i].sv;
      m_tready = tbl[i].mr;
      sample();
      chk("t2_s_tready", 64'(s_tready), 64'(tbl[i].e_str));
      chk("t2_m_tvalid", 64'(m_tvalid), 64'(tbl[i].e_mv));
      chk("t2_occ", 64'(occupancy), 64'(tbl[i].e_occ));
      advance();
    end
    chk("t2_count", 64'(n_out - base), 64'd4);

    // 3: random valid/ready, ending on a packet boundary
    acc0 = n_in;
    cyc  = 0;
    while (((n_in - acc0) < 10000 || !last_in_tlast) && cyc < 60000) begin
      s_tvalid = ($urandom_range(0, 1) == 1);
      m_tready = ($urandom_range(0, 1) == 1);
      s_tlast  = ($urandom_range(0, 3) == 0);
      sample();
      advance();
      cyc++;
    end
    chk("t3_budget", 64'(cyc < 60000), 64'd1);
    s_tvalid = 1'b0; m_tready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      sample();
      advance();
    end
    chk("t3_drained", 64'(sb_q.size()), 64'd0);
    chk("t3_occ_zero", 64'(occupancy), 64'd0);

    // 4: pause during a 5-beat packet; next packet resumes after release
    base = n_out;
    acc0 = seq;
    m_tready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      s_tvalid = ((seq - acc0) < 8);
      s_tlast  = ((seq - acc0) == 4) || ((seq - acc0) == 7);
      pause    = (c >= 3 && c < 13);
      sample();
      chk("t4_m_tvalid", 64'(m_tvalid), 64'((c >= 2 && c <= 6) || (c >= 14 && c <= 16)));
      chk("t4_paused", 64'(paused), 64'(c >= 7 && c <= 13));
      if (c == 7) chk("t4_pkt1_done", 64'(n_out - base), 64'd5);
      advance();
    end
    chk("t4_count", 64'(n_out - base), 64'd8);

    // 5: pause while a beat is stalled on egress with no packet open
    base = n_out;
    for (int c = 0; c < 12; c++) begin
      s_tvalid = (c == 0 || c == 3);
      s_tlast  = 1'b1;
      m_tready = (c == 5) || (c >= 9);
      pause    = (c >= 2 && c < 8);
      sample();
      chk("t5_m_tvalid", 64'(m_tvalid), 64'((c >= 2 && c <= 5) || c == 9));
      chk("t5_paused", 64'(paused), 64'(c >= 6 && c <= 8));
      advance();
    end
    chk("t5_count", 64'(n_out - base), 64'd2);

    // 6: reset mid-packet with three beats held
    pause = 1'b0;
    for (int c = 0; c < 4; c++) begin
      s_tvalid = 1'b1;
      s_tlast  = 1'b0;
      m_tready = (c == 2);
      sample();
      chk("t6_s_tready", 64'(s_tready), 64'd1);
      advance();
    end
    s_tvalid = 1'b0; m_tready = 1'b0;
    sample();
    chk("t6_occ3", 64'(occupancy), 64'd3);
    advance();
    rst_n = 1'b0; s_tvalid = 1'b1;
    sample();
    chk("t6_rst_s_tready", 64'(s_tready), 64'd0);
    chk("t6_rst_m_tvalid", 64'(m_tvalid), 64'd0);
    chk("t6_rst_paused", 64'(paused), 64'd0);
    advance();
    rst_n = 1'b1; s_tvalid = 1'b0; m_tready = 1'b1; pause = 1'b1;
    sample();
    chk("t6_after_m_tvalid", 64'(m_tvalid), 64'd0);
    chk("t6_after_occ", 64'(occupancy), 64'd0);
    chk("t6_after_s_tready", 64'(s_tready), 64'd1);
    chk("t6_after_paused", 64'(paused), 64'd0);
    advance();
    sample();
    chk("t6_gate_after_rst", 64'(paused), 64'd1);
    advance();
    pause = 1'b0;
    sample();
    advance();
    base = n_out;
    for (int c = 0; c < 5; c++) begin
      s_tvalid = (c == 0);
      s_tlast  = 1'b1;
      sample();
      chk("t6_paused_released", 64'(paused), 64'd0);
      advance();
    end
    chk("t6_fresh_count", 64'(n_out - base), 64'd1);
    chk("t6_sb_empty", 64'(sb_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
